mdu_seq: RTL
============

# mdu_seq

Multi-cycle multiply/divide sequencer that sits beside the EX stage and owns the iterative MULT/MULTU/MADD/MADDU/MSUB/MSUBU/DIV/DIVU datapath. EX raises a request, holds its operands, and stalls the pipeline through this block until the 64-bit {HI,LO} result is ready. The sequencer drives the counter, sign fix-up and HI/LO accumulate steps. It replaces the EX-local cnt/hilo_temp loop with one shared radix-2 engine.

## Interface
Parameters:
- WIDTH, 32, operand width; result is 2*WIDTH.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-low reset.
- start_i  in  1  EX request. Level signal, held high with stable op/operands until ready_o.
- annul_i  in  1  flush/exception. Cancels any operation in progress.
- op_i  in  3  operation code, encodings from mdu_pkg.
- opdata1_i  in  WIDTH  multiplicand / dividend.
- opdata2_i  in  WIDTH  multiplier / divisor.
- hi_i  in  WIDTH  forwarded HI, used by MADD/MSUB. Sampled at acceptance.
- lo_i  in  WIDTH  forwarded LO, same sampling rule as hi_i.
- result_o  out  2*WIDTH  {HI,LO}. For divide, HI=remainder and LO=quotient. Valid only while ready_o is high.
- ready_o  out  1  result valid, one-cycle pulse.
- stallreq_o  out  1  pipeline stall request to ctrl.

## Operation
- States: IDLE, CALC, FIX, DONE.
- IDLE:
  - start_i & ~annul_i → latch op, operand magnitudes (signed ops negate negative operands), sign flags and {hi_i,lo_i]; clear the 5-bit counter; go to CALC.
  - DIV/DIVU with opdata2_i==0 → go straight to DONE with result 0.
- CALC, one iteration per cycle, counter 0..31:
  - Multiply: shift-add into a 64-bit product register.
  - Divide: restoring shift-subtract on a 65-bit remainder/quotient register.
  - Counter==31 → FIX.
- FIX, one cycle:
  - Signed multiply: negate the product if sign1^sign2.
  - Signed divide: negate the quotient if sign1^sign2; the remainder takes the sign of the dividend.
  - MADD(U): result = {HI,LO} + product, mod 2^64.
  - MSUB(U): result = {HI,LO} − product, mod 2^64.
  - Go to DONE.
- DONE: ready_o=1 and result_o is valid. Always go to IDLE next cycle, whether or not start_i is still high.
- stallreq_o = start_i & ~annul_i & ~(state==DONE). This is combinational, so the request cycle itself already stalls.
- Abort: annul_i, or start_i low in CALC/FIX, → IDLE next edge. No ready_o pulse, and latched data is discarded.
- Reset: all outputs 0, state IDLE, counter 0. Reset asserted mid-operation aborts it with no ready_o.

## Timing
- Cycle 0 is the first cycle start_i is seen in IDLE.
- Multiply ops (all six): CALC in cycles 1–32, FIX in 33, ready_o in 34.
- Divide ops: same latency as multiply, ready_o in 34.
- Divide by zero: ready_o in cycle 1.
- stallreq_o is high from cycle 0 through the cycle before ready_o, and low in the ready_o cycle.
- Back-to-back requests: after DONE→IDLE, a new start_i is accepted in the first IDLE cycle. Minimum spacing between ready_o pulses is 35 cycles.
- result_o holds its last value outside DONE. Only ready_o qualifies it.
- annul_i has priority over start_i in every state.

## Configuration
- MDU_DIV_EN defined: the divider path, 65-bit remainder register and divide sign fix-up are compiled in.
- MDU_DIV_EN undefined:
  - DIV/DIVU take the divide-by-zero path: ready_o in cycle 1, result 0.
  - Multiply behaviour and all ports are unchanged.

## Structure
- mdu_pkg holds:
  - op_i encodings: MULT=0, MULTU=1, MADD=2, MADDU=3, MSUB=4, MSUBU=5, DIV=6, DIVU=7.
  - the state enum and the counter width.
  - helpers is_signed(op) and is_div(op).
- Sub-module mdu_step: combinational single iteration. Takes the mode plus the current product or remainder and returns the next value. mdu_seq instantiates it once.

## Test plan
- MULT 0xFFFFFFFE × 0x00000003 → ready_o in cycle 34 with result_o=0xFFFFFFFF_FFFFFFFA. stallreq_o high in cycles 0–33.
- MADDU, {hi_i,lo_i}=0x00000000_00000005, 0x00010000 × 0x00010000 → result_o=0x00000001_00000005.
- MSUB, {hi_i,lo_i}=0, 0x00000002 × 0xFFFFFFFD → result_o=0x00000000_00000006.
- DIV 0xFFFFFFF9 (−7) / 0x00000002 → LO=0xFFFFFFFD, HI=0xFFFFFFFF, ready_o in cycle 34.
- DIVU 0x12345678 / 0 → ready_o in cycle 1 with result_o=0. Without MDU_DIV_EN, DIV 10/3 also gives ready_o in cycle 1 with result_o=0.
- MULT with annul_i pulsed in cycle 10 → no ready_o, IDLE in cycle 11. A new MULTU 3×4 starting in cycle 11 → ready_o in cycle 45 with result_o=0x00000000_0000000C.

Source files
------------

// File: rtl/mdu_pkg.sv
// mdu_pkg: op encodings, sequencer states and helpers shared by the
// multiply/divide sequencer. Divider gated by MDU_DIV_EN.
package mdu_pkg;

  typedef enum logic [2:0] {
    OP_MULT  = 3'd0,
    OP_MULTU = 3'd1,
    OP_MADD  = 3'd2,
    OP_MADDU = 3'd3,
    OP_MSUB  = 3'd4,
    OP_MSUBU = 3'd5,
    OP_DIV   = 3'd6,
    OP_DIVU  = 3'd7
  } mdu_op_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_FIX,
    S_DONE
  } mdu_state_e;

  localparam int CNT_W = 5;

  function automatic logic is_signed(input logic [2:0] op);
    return op == OP_MULT || op == OP_MADD ||
           op == OP_MSUB || op == OP_DIV;
  endfunction

  function automatic logic is_div(input logic [2:0] op);
    return op == OP_DIV || op == OP_DIVU;
  endfunction

endpackage

// File: rtl/mdu_step.sv
// mdu_step: one radix-2 iteration, shift-add multiply or restoring
// shift-subtract divide (divide only with MDU_DIV_EN).
module mdu_step
  import mdu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic               div_mode,
  input  logic [2*WIDTH:0]   cur,
  input  logic [WIDTH-1:0]   opnd,
  output logic [2*WIDTH:0]   nxt
);

  logic [WIDTH:0]   sum;
  logic [2*WIDTH:0] mul_nxt;
  logic             unused_top;

  // Top bit is a carry slot that no iteration reads back.
  assign unused_top = cur[2*WIDTH];

  assign sum = {1'b0, cur[2*WIDTH-1:WIDTH]} + {1'b0, opnd};

  // Add multiplicand into the upper half when the low bit is set, then shift.
  always_comb begin
    if (cur[0])
      mul_nxt = {1'b0, sum, cur[WIDTH-1:1]};
    else
      mul_nxt = {2'b00, cur[2*WIDTH-1:WIDTH], cur[WIDTH-1:1]};
  end

`ifdef MDU_DIV_EN
  logic [WIDTH:0] diff;

  assign diff = cur[2*WIDTH-1:WIDTH-1] - {1'b0, opnd};

  // Shift remainder left; keep the subtraction only when it does not underflow.
  always_comb begin
    if (!div_mode)
      nxt = mul_nxt;
    else if (diff[WIDTH])
      nxt = {cur[2*WIDTH-1:0], 1'b0};
    else
      nxt = {diff, cur[WIDTH-2:0], 1'b1};
  end
`else
  logic unused_div;

  assign unused_div = div_mode;
  assign nxt        = mul_nxt;
`endif

endmodule

// File: rtl/mdu_seq.sv
// mdu_seq: multi-cycle MULT/MADD/MSUB/DIV sequencer beside EX.
// Define MDU_DIV_EN to build the divider; otherwise DIV/DIVU return 0.
module mdu_seq
  import mdu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start_i,
  input  logic               annul_i,
  input  logic [2:0]         op_i,
  input  logic [WIDTH-1:0]   opdata1_i,
  input  logic [WIDTH-1:0]   opdata2_i,
  input  logic [WIDTH-1:0]   hi_i,
  input  logic [WIDTH-1:0]   lo_i,
  output logic [2*WIDTH-1:0] result_o,
  output logic               ready_o,
  output logic               stallreq_o
);

  localparam int PW = 2 * WIDTH;

  mdu_state_e       state;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       op_q;
  logic             sgn1_q;
  logic             sgn2_q;
  logic [WIDTH-1:0] opnd_q;
  logic [PW:0]      acc_q;
  logic [PW:0]      acc_nxt;
  logic [PW-1:0]    hilo_q;
  logic [PW-1:0]    prod;
  logic [PW-1:0]    fix_res;
  logic             neg1;
  logic             neg2;
  logic [WIDTH-1:0] mag1;
  logic [WIDTH-1:0] mag2;
  logic             div_zero;
  logic             abort;

  assign neg1  = is_signed(op_i) & opdata1_i[WIDTH-1];
  assign neg2  = is_signed(op_i) & opdata2_i[WIDTH-1];
  assign mag1  = neg1 ? -opdata1_i : opdata1_i;
  assign mag2  = neg2 ? -opdata2_i : opdata2_i;
  assign abort = annul_i | ~start_i;

`ifdef MDU_DIV_EN
  assign div_zero = is_div(op_i) & (opdata2_i == '0);
`else
  assign div_zero = is_div(op_i);
`endif

  assign stallreq_o = start_i & ~annul_i & (state != S_DONE);

  mdu_step #(
    .WIDTH(WIDTH)
  ) u_step (
    .div_mode(is_div(op_q)),
    .cur     (acc_q),
    .opnd    (opnd_q),
    .nxt     (acc_nxt)
  );

`ifdef MDU_DIV_EN
  logic [WIDTH-1:0] quo;
  logic [WIDTH-1:0] rem;

  // Quotient sign is sign1^sign2; remainder follows the dividend.
  always_comb begin
    quo = acc_q[WIDTH-1:0];
    rem = acc_q[PW-1:WIDTH];
    if (is_signed(op_q) && (sgn1_q ^ sgn2_q))
      quo = -quo;
    if (is_signed(op_q) && sgn1_q)
      rem = -rem;
  end
`endif

  // Sign fix-up of the magnitude product, then HI/LO accumulate.
  always_comb begin
    prod = acc_q[PW-1:0];
    if (is_signed(op_q) && (sgn1_q ^ sgn2_q))
      prod = -prod;
    fix_res = prod;
    unique case (1'b1)
`ifdef MDU_DIV_EN
      is_div(op_q):
        fix_res = {rem, quo};
`endif
      op_q == OP_MADD || op_q == OP_MADDU:
        fix_res = hilo_q + prod;
      op_q == OP_MSUB || op_q == OP_MSUBU:
        fix_res = hilo_q - prod;
      default:
        fix_res = prod;
    endcase
  end

  // Sequencer: accept, iterate, fix up, pulse ready for one cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= S_IDLE;
      cnt      <= '0;
      op_q     <= '0;
      sgn1_q   <= 1'b0;
      sgn2_q   <= 1'b0;
      opnd_q   <= '0;
      acc_q    <= '0;
      hilo_q   <= '0;
      result_o <= '0;
      ready_o  <= 1'b0;
    end else begin
      ready_o <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (start_i && !annul_i) begin
            op_q   <= op_i;
            sgn1_q <= neg1;
            sgn2_q <= neg2;
            hilo_q <= {hi_i, lo_i};
            cnt    <= '0;
            opnd_q <= is_div(op_i) ? mag2 : mag1;
            acc_q  <= {{(WIDTH + 1){1'b0}},
                       is_div(op_i) ? mag1 : mag2};
            if (div_zero) begin
              result_o <= '0;
              ready_o  <= 1'b1;
              state    <= S_DONE;
            end else begin
              state <= S_CALC;
            end
          end
        end
        S_CALC: begin
          if (abort) begin
            state <= S_IDLE;
          end else begin
            acc_q <= acc_nxt;
            cnt   <= cnt + 1'b1;
            if (cnt == CNT_W'(WIDTH - 1))
              state <= S_FIX;
          end
        end
        S_FIX: begin
          if (abort) begin
            state <= S_IDLE;
          end else begin
            result_o <= fix_res;
            ready_o  <= 1'b1;
            state    <= S_DONE;
          end
        end
        S_DONE: state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
